// File: rtl/rv32i_pkg.sv
// Opcode constants, datapath select encodings and FSM state type shared by the
// RV32I multi-cycle controller and its sub-blocks.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_SR   = 3'b101;

  // Encodings are shared with the single-cycle decoder so the datapath muxes are untouched.
  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_J = 3'd4,
    IMM_U = 3'd5
  } imm_sel_t;

  typedef enum logic [2:0] {
    ALU_NORMAL = 3'd0,
    ALU_ALT    = 3'd1,
    ALU_PASS_B = 3'd3,
    ALU_ADD    = 3'd4
  } alu_sel_t;

  typedef enum logic [1:0] {
    WB_DMEM = 2'd0,
    WB_ALU  = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } ctrl_state_t;

  function automatic logic opcode_known(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: opcode_known = 1'b1;
      default:                                opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Shared single-port memory handshake between the controller (master) and the
// memory (slave); instruction fetch and load/store both use this port.
interface rv32i_multicycle_ctrl_if;
  logic mem_req;
  logic mem_rw;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_rw, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_rw, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/rv32i_branch_eval.sv
// Branch resolution: taken decision and unsigned-compare select from funct3 and
// the datapath comparator results.
module rv32i_branch_eval
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_eq,
  input  logic       br_lt,
  output logic       taken,
  output logic       br_un
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = !br_eq;
      F3_BLT, F3_BLTU:  taken = br_lt;
      F3_BGE, F3_BGEU:  taken = !br_lt;
      default:          taken = 1'b0;
    endcase
  end

  assign br_un = (funct3 == F3_BLTU) || (funct3 == F3_BGEU);

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with per-state datapath
// controls. Define RV32I_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of NOPing them.
//
//   state  | meaning
//   FETCH  | read instruction at PC, load IR on mem_ready
//   DECODE | register file read, opcode check
//   EXEC   | ALU op into ALU-out; branches resolve and retire here
//   MEM    | load/store access at ALU-out; stores retire here
//   WB     | register write-back and PC update
//   TRAP   | illegal opcode seen, frozen until reset
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         instruction,
  input  logic                    BrEq,
  input  logic                    BrLT,
  rv32i_multicycle_ctrl_if.master mem,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    alu_out_we,
  output logic                    reg_write_en,
  output logic                    pc_sel,
  output logic [2:0]              imm_sel,
  output logic [2:0]              alu_op,
  output logic [2:0]              alu_sel,
  output logic                    busA_sel_mux,
  output logic                    busB_sel_mux,
  output logic                    BrUn,
  output logic [1:0]              wb_sel,
  output logic                    instr_done,
  output logic                    illegal
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  logic        illegal_q;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_alt;
  logic        br_taken;
  logic        br_un;
  logic        unused_instr_bits;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign funct7_alt = instruction[30];
  assign unused_instr_bits = ^{instruction[XLEN-1:31], instruction[29:15], instruction[11:7]};

  rv32i_branch_eval u_branch_eval (
    .funct3 (funct3),
    .br_eq  (BrEq),
    .br_lt  (BrLT),
    .taken  (br_taken),
    .br_un  (br_un)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)                      illegal_q <= 1'b0;
    else if (state_next == S_TRAP) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  // Outputs are gated while rst is high so no write can slip out in the reset cycle.
  assign illegal = illegal_q && !rst;

  always_comb begin
    state_next       = state;
    mem.mem_req      = 1'b0;
    mem.mem_rw       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    alu_out_we       = 1'b0;
    reg_write_en     = 1'b0;
    pc_sel           = 1'b0;
    imm_sel          = IMM_R;
    alu_op           = 3'b000;
    alu_sel          = ALU_NORMAL;
    busA_sel_mux     = 1'b0;
    busB_sel_mux     = 1'b0;
    BrUn             = 1'b0;
    wb_sel           = WB_DMEM;
    instr_done       = 1'b0;

    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
          end
        end

        S_DECODE: begin
          state_next = S_EXEC;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
          if (!opcode_known(opcode)) state_next = S_TRAP;
`endif
        end

        S_EXEC: begin
          alu_out_we = 1'b1;
          alu_op     = funct3;
          case (opcode)
            OPC_OP: begin
              alu_sel    = funct7_alt ? ALU_ALT : ALU_NORMAL;
              state_next = S_WB;
            end
            OPC_OPIMM: begin
              imm_sel      = IMM_I;
              busB_sel_mux = 1'b1;
              // Only SRAI uses the alt ALU mode; bit 30 of other I-type immediates is data.
              alu_sel      = (funct3 == F3_SR && funct7_alt) ? ALU_ALT : ALU_NORMAL;
              state_next   = S_WB;
            end
            OPC_LOAD: begin
              imm_sel      = IMM_I;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              state_next   = S_MEM;
            end
            OPC_STORE: begin
              imm_sel      = IMM_S;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              state_next   = S_MEM;
            end
            OPC_BRANCH: begin
              imm_sel      = IMM_B;
              busA_sel_mux = 1'b1;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              BrUn         = br_un;
              pc_sel       = br_taken;
              pc_we        = 1'b1;
              instr_done   = 1'b1;
              state_next   = S_FETCH;
            end
            OPC_JAL: begin
              imm_sel      = IMM_J;
              busA_sel_mux = 1'b1;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              state_next   = S_WB;
            end
            OPC_JALR: begin
              imm_sel      = IMM_I;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              state_next   = S_WB;
            end
            OPC_LUI: begin
              imm_sel      = IMM_U;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_PASS_B;
              state_next   = S_WB;
            end
            OPC_AUIPC: begin
              imm_sel      = IMM_U;
              busA_sel_mux = 1'b1;
              busB_sel_mux = 1'b1;
              alu_sel      = ALU_ADD;
              state_next   = S_WB;
            end
            default: begin
              pc_we      = 1'b1;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_rw       = (opcode == OPC_STORE);
          if (mem.mem_ready) begin
            if (opcode == OPC_STORE) begin
              pc_we      = 1'b1;
              instr_done = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end

        S_WB: begin
          reg_write_en = 1'b1;
          pc_we        = 1'b1;
          instr_done   = 1'b1;
          state_next   = S_FETCH;
          if (opcode == OPC_JAL || opcode == OPC_JALR) begin
            wb_sel = WB_PC4;
            pc_sel = 1'b1;
          end else if (opcode == OPC_LOAD) begin
            wb_sel = WB_DMEM;
          end else begin
            wb_sel = WB_ALU;
          end
        end

        S_TRAP: state_next = S_TRAP;

        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: per-cycle output check against a
// phase-level model, directed cases from the test plan, then randomized instructions.
module tb_rv32i_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mem_req;
    logic       mem_rw;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       alu_out_we;
    logic       reg_write_en;
    logic       pc_sel;
    logic [2:0] imm_sel;
    logic [2:0] alu_op;
    logic [2:0] alu_sel;
    logic       bus_a;
    logic       bus_b;
    logic       br_un;
    logic [1:0] wb_sel;
    logic       instr_done;
    logic       illegal;
  } ovec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        BrEq, BrLT;
  logic        ir_we, pc_we, alu_out_we, reg_write_en, pc_sel;
  logic [2:0]  imm_sel, alu_op, alu_sel;
  logic        busA_sel_mux, busB_sel_mux, BrUn;
  logic [1:0]  wb_sel;
  logic        instr_done, illegal;

  rv32i_multicycle_ctrl_if mif ();

  rv32i_multicycle_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .BrEq         (BrEq),
    .BrLT         (BrLT),
    .mem          (mif),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .alu_out_we   (alu_out_we),
    .reg_write_en (reg_write_en),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .alu_op       (alu_op),
    .alu_sel      (alu_sel),
    .busA_sel_mux (busA_sel_mux),
    .busB_sel_mux (busB_sel_mux),
    .BrUn         (BrUn),
    .wb_sel       (wb_sel),
    .instr_done   (instr_done),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    failed = 0;
  ovec_t exp_vec;
  ovec_t got;
  bit    exp_valid = 1'b0;
  string exp_tag = "";

  int cyc_cnt = 0, last_cpi = 0, retired = 0, pc_we_cnt = 0, regw_cnt = 0;
  int exp_retired = 0, exp_regw = 0;

  assign got = {mif.mem_req, mif.mem_rw, mif.mem_addr_sel, ir_we, pc_we, alu_out_we,
                reg_write_en, pc_sel, imm_sel, alu_op, alu_sel, busA_sel_mux,
                busB_sel_mux, BrUn, wb_sel, instr_done, illegal};

  always @(negedge clk) begin
    if (exp_valid) begin
      tests++;
      if (got !== exp_vec) begin
        failed++;
        $display("FAIL %s @%0t: got %h expected %h", exp_tag, $time, got, exp_vec);
      end
    end
  end

  // Observed cycles-per-instruction and strobe counts, measured purely from DUT outputs.
  always @(negedge clk) begin
    if (rst) begin
      cyc_cnt = 0;
    end else begin
      cyc_cnt++;
      if (pc_we) pc_we_cnt++;
      if (reg_write_en) regw_cnt++;
      if (instr_done) begin
        last_cpi = cyc_cnt;
        cyc_cnt  = 0;
        retired++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got_v, input int exp_v);
    tests++;
    if (got_v != exp_v) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, got_v, exp_v);
    end
  endtask

  task automatic drive(input ovec_t e, input string tag);
    exp_vec   = e;
    exp_tag   = tag;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mif.mem_ready = 1'($urandom);
    drive('0, "reset");
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b30);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = op;
    r[14:12] = f3;
    r[30]    = b30;
    return r;
  endfunction

  function automatic bit is_known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  // Expected EXEC-cycle controls straight from the per-format selection table.
  function automatic ovec_t exec_exp(input logic [31:0] ins, input logic beq, input logic blt);
    ovec_t      e;
    logic [2:0] f3;
    e            = '0;
    f3           = ins[14:12];
    e.alu_out_we = 1'b1;
    e.alu_op     = f3;
    case (ins[6:0])
      OP_R:     e.alu_sel = ins[30] ? 3'd1 : 3'd0;
      OP_I:     begin e.imm_sel = 3'd1; e.bus_b = 1'b1; e.alu_sel = (f3 == 3'b101 && ins[30]) ? 3'd1 : 3'd0; end
      OP_LD:    begin e.imm_sel = 3'd1; e.bus_b = 1'b1; e.alu_sel = 3'd4; end
      OP_ST:    begin e.imm_sel = 3'd2; e.bus_b = 1'b1; e.alu_sel = 3'd4; end
      OP_BR: begin
        e.imm_sel = 3'd3; e.bus_a = 1'b1; e.bus_b = 1'b1; e.alu_sel = 3'd4;
        e.br_un   = (f3 == 3'b110 || f3 == 3'b111);
        e.pc_sel  = (f3[2] ? blt : beq) ^ f3[0];
        e.pc_we   = 1'b1;
        e.instr_done = 1'b1;
      end
      OP_JAL:   begin e.imm_sel = 3'd4; e.bus_a = 1'b1; e.bus_b = 1'b1; e.alu_sel = 3'd4; end
      OP_JALR:  begin e.imm_sel = 3'd1; e.bus_b = 1'b1; e.alu_sel = 3'd4; end
      OP_LUI:   begin e.imm_sel = 3'd5; e.bus_b = 1'b1; e.alu_sel = 3'd3; end
      OP_AUIPC: begin e.imm_sel = 3'd5; e.bus_a = 1'b1; e.bus_b = 1'b1; e.alu_sel = 3'd4; end
      default:  begin e.pc_we = 1'b1; e.instr_done = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic beq, input logic blt);
    logic [6:0] op;
    ovec_t      e;
    op          = ins[6:0];
    instruction = ins;
    BrEq        = beq;
    BrLT        = blt;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mem_req = 1'b1; e.ir_we = (i == fw);
      mif.mem_ready = (i == fw);
      drive(e, "fetch");
    end
    mif.mem_ready = 1'($urandom);
    drive('0, "decode");
    if (!is_known(op) && TRAP_EN) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.illegal = 1'b1;
        mif.mem_ready = 1'($urandom);
        drive(e, "trap");
      end
      do_reset();
      return;
    end
    mif.mem_ready = 1'($urandom);
    drive(exec_exp(ins, beq, blt), "exec");
    if (op == OP_LD || op == OP_ST) begin
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_rw = (op == OP_ST);
        if (i == mw && op == OP_ST) begin e.pc_we = 1'b1; e.instr_done = 1'b1; end
        mif.mem_ready = (i == mw);
        drive(e, "mem");
      end
    end
    if (is_known(op) && op != OP_BR && op != OP_ST) begin
      e = '0; e.reg_write_en = 1'b1; e.pc_we = 1'b1; e.instr_done = 1'b1;
      if (op == OP_JAL || op == OP_JALR) begin e.wb_sel = 2'd2; e.pc_sel = 1'b1; end
      else if (op == OP_LD) e.wb_sel = 2'd0;
      else e.wb_sel = 2'd1;
      mif.mem_ready = 1'($urandom);
      drive(e, "wb");
      exp_regw++;
    end
    exp_retired++;
  endtask

  task automatic run_reset_in_mem(input logic [31:0] ins);
    ovec_t e;
    instruction = ins;
    e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1;
    mif.mem_ready = 1'b1;
    drive(e, "rfetch");
    mif.mem_ready = 1'b0;
    drive('0, "rdecode");
    drive(exec_exp(ins, BrEq, BrLT), "rexec");
    e = '0; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    drive(e, "rmem_wait");
    do_reset();
  endtask

  function automatic int wait_rand();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  int          r0, p0, g0;
  int          cls;
  logic [6:0]  op;
  logic [2:0]  f3;

  initial begin
    rst = 1'b1; instruction = '0; BrEq = 1'b0; BrLT = 1'b0; mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    drive('0, "reset_state");
    drive('0, "reset_state");
    rst = 1'b0;

    g0 = regw_cnt; r0 = retired;
    run_instr(mk(OP_I, 3'b000, 1'b0), 0, 0, 1'b0, 1'b0);
    check("addi_cpi", last_cpi, 4);
    check("addi_regw", regw_cnt - g0, 1);
    check("addi_retire", retired - r0, 1);

    run_instr(mk(OP_LD, 3'b010, 1'b0), 2, 2, 1'b0, 1'b0);
    check("lw_wait_cpi", last_cpi, 9);

    run_instr(mk(OP_BR, 3'b000, 1'b0), 0, 0, 1'b1, 1'b0);
    check("beq_taken_cpi", last_cpi, 3);
    run_instr(mk(OP_BR, 3'b000, 1'b0), 0, 0, 1'b0, 1'b0);
    check("beq_fall_cpi", last_cpi, 3);
    run_instr(mk(OP_BR, 3'b111, 1'b0), 0, 0, 1'b0, 1'b1);
    check("bgeu_cpi", last_cpi, 3);

    g0 = regw_cnt;
    run_instr(mk(OP_ST, 3'b010, 1'b0), 0, 0, 1'b0, 1'b0);
    check("sw_cpi", last_cpi, 4);
    check("sw_regw", regw_cnt - g0, 0);

    r0 = retired;
    run_instr(mk(7'b1111111, 3'b000, 1'b0), 0, 0, 1'b0, 1'b0);
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    check("illegal_trap_no_retire", retired - r0, 0);
`else
    check("illegal_nop_cpi", last_cpi, 3);
    check("illegal_nop_retire", retired - r0, 1);
`endif

    p0 = pc_we_cnt; g0 = regw_cnt;
    run_reset_in_mem(mk(OP_LD, 3'b010, 1'b0));
    check("rst_mem_pc_we", pc_we_cnt - p0, 0);
    check("rst_mem_regw", regw_cnt - g0, 0);
    run_instr(mk(OP_R, 3'b000, 1'b1), 0, 0, 1'b0, 1'b0);
    check("after_rst_cpi", last_cpi, 4);

    for (int n = 0; n < 300; n++) begin
      cls = int'($urandom_range(0, 9));
      f3  = 3'($urandom);
      case (cls)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        5: op = OP_JAL;
        6: op = OP_JALR;
        7: op = OP_LUI;
        8: op = OP_AUIPC;
        default: begin
          case ($urandom_range(0, 2))
            0: op = 7'b1111111;
            1: op = 7'b0001111;
            default: op = 7'b1110011;
          endcase
        end
      endcase
      if (op == OP_BR) begin
        while (f3 == 3'b010 || f3 == 3'b011) f3 = 3'($urandom);
      end
      run_instr(mk(op, f3, 1'($urandom)), wait_rand(), wait_rand(), 1'($urandom), 1'($urandom));
    end

    exp_valid = 1'b0;
    check("total_retired", retired, exp_retired);
    check("total_pc_we", pc_we_cnt, exp_retired);
    check("total_reg_write", regw_cnt, exp_regw);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
